// File: rtl/dct_idct_frame_sched.sv
// -----------------------------------------------------------------------------
// dct_idct_frame_sched
//
// Frame-level scheduler for a dct -> idct chain. It meters a pixel stream into
// the dct while the dct reports it is reading, counts 8x8 blocks coming out of
// both transforms, drives the idct approximation select (rapx) from a block
// index window, and repacks idct results into an 8-bit output stream. It flags
// frame completion, input underflow and drain timeout.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   frame_start            one-cycle pulse, starts a frame (IDLE only)
//   num_blocks             blocks per frame (latched at frame_start, 0 = ignore)
//   apx_lo, apx_hi         rapx window [apx_lo, apx_hi) over block index
//   pix_valid/pix_data     input pixel stream
//   pix_ready              pixel accepted when pix_valid & pix_ready
//   dct_start, dct_din     to dct
//   dct_reading, dct_done  from dct
//   idct_done, idct_dout   from idct
//   rapx                   to idct, constant across a block
//   out_valid, out_pix     8-bit slice of idct_dout, 1-cycle latency
//   busy                   frame in progress (state != IDLE)
//   frame_done             one-cycle pulse at end of frame
//   err_underflow          sticky, cleared by an accepted frame_start
//   err_timeout            sticky, cleared by an accepted frame_start
// -----------------------------------------------------------------------------
module dct_idct_frame_sched #(
  parameter int DW        = 32,
  parameter int OUT_LSB   = 13,
  parameter int BLK_WORDS = 64,
  parameter int TO_CYCLES = 16384
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [15:0]   num_blocks,
  input  logic [15:0]   apx_lo,
  input  logic [15:0]   apx_hi,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          dct_start,
  output logic [DW-1:0] dct_din,
  input  logic          dct_reading,
  input  logic          dct_done,
  input  logic          idct_done,
  input  logic [DW-1:0] idct_dout,
  output logic          rapx,
  output logic          out_valid,
  output logic [7:0]    out_pix,
  output logic          busy,
  output logic          frame_done,
  output logic          err_underflow,
  output logic          err_timeout
);

  localparam int WCW = $clog2(BLK_WORDS + 1);
  localparam int TOW = $clog2(TO_CYCLES + 1);
  localparam logic [21:0]    BLK_W22 = 22'(BLK_WORDS);
  localparam logic [WCW-1:0] BLK_WC  = WCW'(BLK_WORDS);
  localparam logic [TOW-1:0] TO_LIM  = TOW'(TO_CYCLES);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     nblk_q, nblk_d;
  logic [15:0]     lo_q, lo_d;
  logic [15:0]     hi_q, hi_d;
  logic [21:0]     in_cnt_q, in_cnt_d;
  logic [DW-1:0]   dct_din_q, dct_din_d;
  logic            dct_start_q, dct_start_d;
  logic [15:0]     dct_blk_q, dct_blk_d;
  logic            dct_done_prev_q;
  logic            rapx_q, rapx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [15:0]     out_blk_q, out_blk_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_pix_q, out_pix_d;
  logic [TOW-1:0]  wd_q, wd_d;
  logic            err_uf_q, err_uf_d;
  logic            err_to_q, err_to_d;

  logic [21:0]     total;
  logic            in_lt_total;
  logic            dct_rise;
  logic            active;

  assign total       = {6'd0, nblk_q} * BLK_W22;
  assign in_lt_total = (in_cnt_q < total);
  assign dct_rise    = dct_done & ~dct_done_prev_q;
  assign active      = (state_q == FEED) || (state_q == DRAIN);

  assign pix_ready     = (state_q == FEED) & dct_reading & in_lt_total;
  assign dct_start     = dct_start_q;
  assign dct_din       = dct_din_q;
  assign rapx          = rapx_q;
  assign out_valid     = out_valid_q;
  assign out_pix       = out_pix_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == DONE);
  assign err_underflow = err_uf_q;
  assign err_timeout   = err_to_q;

  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    in_cnt_d    = in_cnt_q;
    dct_din_d   = dct_din_q;
    dct_start_d = dct_start_q;
    dct_blk_d   = dct_blk_q;
    rapx_d      = rapx_q;
    wcnt_d      = wcnt_q;
    out_blk_d   = out_blk_q;
    out_valid_d = 1'b0;
    out_pix_d   = out_pix_q;
    wd_d        = wd_q;
    err_uf_d    = err_uf_q;
    err_to_d    = err_to_q;

    case (state_q)
      IDLE: begin
        if (frame_start && (num_blocks != 16'd0)) begin
          nblk_d      = num_blocks;
          lo_d        = apx_lo;
          hi_d        = apx_hi;
          err_uf_d    = 1'b0;
          err_to_d    = 1'b0;
          dct_start_d = 1'b1;
          rapx_d      = 1'b0;
          in_cnt_d    = '0;
          dct_blk_d   = '0;
          out_blk_d   = '0;
          wcnt_d      = '0;
          wd_d        = '0;
          state_d     = FEED;
        end
      end
      FEED: begin
        if (pix_valid && pix_ready) begin
          dct_din_d = pix_data;
          in_cnt_d  = in_cnt_q + 22'd1;
        end
        // The dct keeps reading the held dct_din when the source starves.
        if (dct_reading && !pix_valid && in_lt_total) begin
          err_uf_d = 1'b1;
        end
        if ((in_cnt_q == total) && !dct_reading) begin
          dct_start_d = 1'b0;
          wd_d        = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Watchdog measures cycles since the last output word (or DRAIN entry).
        wd_d = out_valid_q ? '0 : wd_q + 1'b1;
        if (out_blk_q == nblk_q) begin
          state_d = DONE;
        end else if (wd_d == TO_LIM) begin
          err_to_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (active) begin
      // rapx is decided once per block, from the index of the block whose
      // dct output burst is starting.
      if (dct_rise) begin
        dct_blk_d = dct_blk_q + 16'd1;
        rapx_d    = (lo_q <= dct_blk_q) && (dct_blk_q < hi_q);
      end
      if (idct_done) begin
        // Words past one block inside a single burst are dropped.
        if (wcnt_q < BLK_WC) begin
          out_valid_d = 1'b1;
          out_pix_d   = idct_dout[OUT_LSB +: 8];
          wcnt_d      = wcnt_q + 1'b1;
          if (wcnt_q == BLK_WC - 1'b1) begin
            out_blk_d = out_blk_q + 16'd1;
          end
        end
      end else begin
        wcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      nblk_q          <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      in_cnt_q        <= '0;
      dct_din_q       <= '0;
      dct_start_q     <= 1'b0;
      dct_blk_q       <= '0;
      dct_done_prev_q <= 1'b0;
      rapx_q          <= 1'b0;
      wcnt_q          <= '0;
      out_blk_q       <= '0;
      out_valid_q     <= 1'b0;
      out_pix_q       <= '0;
      wd_q            <= '0;
      err_uf_q        <= 1'b0;
      err_to_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      nblk_q          <= nblk_d;
      lo_q            <= lo_d;
      hi_q            <= hi_d;
      in_cnt_q        <= in_cnt_d;
      dct_din_q       <= dct_din_d;
      dct_start_q     <= dct_start_d;
      dct_blk_q       <= dct_blk_d;
      dct_done_prev_q <= dct_done;
      rapx_q          <= rapx_d;
      wcnt_q          <= wcnt_d;
      out_blk_q       <= out_blk_d;
      out_valid_q     <= out_valid_d;
      out_pix_q       <= out_pix_d;
      wd_q            <= wd_d;
      err_uf_q        <= err_uf_d;
      err_to_q        <= err_to_d;
    end
  end

endmodule

// File: doc/dct_idct_frame_sched.md
Name: dct_idct_frame_sched

Overview:
Frame-level scheduler for the dct -> idct chain. It accepts a pixel stream and meters it into the dct while the dct asserts reading, and counts 8x8 blocks through both transforms. It drives the idct approximation select (rapx) from a programmable block-index window and packs idct results into an 8-bit output stream. It also flags frame completion, input underflow and drain timeout, replacing ad-hoc bench-side sequencing.

Parameters:
DW, 32, width of pixel, dct_din and idct_dout words
OUT_LSB, 13, LSB of the 8-bit field taken from idct_dout
BLK_WORDS, 64, words per block (8x8)
TO_CYCLES, 16384, drain watchdog limit in cycles without output progress

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse; starts a frame
num_blocks  in  16  blocks per frame, latched at frame_start
apx_lo  in  16  first block index with rapx=1, latched at frame_start
apx_hi  in  16  first block index after the window with rapx=0, latched at frame_start
pix_valid  in  1  input pixel valid
pix_data  in  DW  input pixel
pix_ready  out  1  pixel accepted when pix_valid&pix_ready
dct_start  out  1  to dct start
dct_din  out  DW  to dct din
dct_reading  in  1  from dct reading
dct_done  in  1  from dct done, high for one block's output burst
idct_done  in  1  from idct done, high for one block's output burst
idct_dout  in  DW  from idct dout
rapx  out  1  to idct rapx
out_valid  out  1  out_pix valid
out_pix  out  8  idct_dout[OUT_LSB+7:OUT_LSB]
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame
err_underflow  out  1  sticky; cleared by frame_start
err_timeout  out  1  sticky; cleared by frame_start

Behaviour:
- Reset: state=IDLE; every output and counter is 0. Reset asserted mid-frame aborts the frame; the block is in IDLE the next cycle.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: frame_start with num_blocks!=0 latches num_blocks, apx_lo and apx_hi, clears the error flags, sets dct_start=1 and moves to FEED. frame_start with num_blocks==0 is ignored. frame_start in any other state is ignored.
- FEED:
  - total = num_blocks*BLK_WORDS (22-bit).
  - pix_ready = dct_reading & (in_cnt < total), combinational.
  - On an accepted beat: dct_din <= pix_data, in_cnt++. Otherwise dct_din holds.
  - dct_reading=1 with pix_valid=0 and in_cnt<total sets err_underflow; the dct consumes the held value.
- FEED exit: once in_cnt==total and dct_reading==0, dct_start<=0 and the block moves to DRAIN.
- Block counting:
  - dct_blk increments on each rising edge of dct_done.
  - rapx is registered and updates only on a dct_done rising edge: rapx <= (apx_lo <= dct_blk_new-1 < apx_hi). It is therefore constant across a block.
  - apx_lo >= apx_hi gives rapx=0 for all blocks.
- Output path (FEED and DRAIN):
  - While idct_done=1 and wcnt<BLK_WORDS: out_valid=1 and out_pix=slice, both registered (1-cycle latency), and wcnt++.
  - When wcnt reaches BLK_WORDS: out_blk++. wcnt clears when idct_done=0.
  - Words beyond BLK_WORDS within one burst are dropped.
- DRAIN:
  - The watchdog counts cycles with no out_valid and resets on each out_valid.
  - out_blk==num_blocks moves to DONE.
  - Watchdog reaching TO_CYCLES sets err_timeout and moves to DONE.
- DONE: frame_done=1 for one cycle, then IDLE. rapx holds its value until the next frame_start, which clears it.
- Simultaneous events: an accepted beat and a dct_done edge in the same cycle both take effect. The last output word and the DRAIN entry in the same cycle: DRAIN evaluates the updated out_blk.

Test Plan:
- Single frame: num_blocks=1, pixels 0..63, dct_reading held 64 cycles. Required: 64 accepted beats, dct_start drops after reading falls, 64 out_valid, one frame_done, busy low after it.
- Approximation window: num_blocks=4, apx_lo=1, apx_hi=3. Required: rapx = 0,1,1,0 across dct_done edges 1..4, stable within each block.
- Empty window: apx_lo=5, apx_hi=2. Required: rapx=0 for the whole frame.
- Underflow: pix_valid dropped for 3 cycles while dct_reading=1. Required: err_underflow=1 and dct_din holds the last value. A later frame_start clears the flag.
- Timeout: idct_done never asserted after feeding num_blocks=2. Required: err_timeout=1 and frame_done exactly TO_CYCLES cycles after the last out_valid/DRAIN entry.
- Reset and ignored starts: reset pulsed mid-FEED at in_cnt=30. Required: all outputs 0 next cycle. frame_start with num_blocks=0 leaves the block in IDLE. A second frame_start while busy is ignored.
